// File: rtl/device_rx_if.sv
// Signal bundle between the receive core and its channel/host side.
// The environment drives through master; the device core uses slave.
interface device_rx_if;
    logic        start;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_cd;
    logic        p_error;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic [4:0]  addr_rd;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;

    modport master (
        output start, rx_data, rx_valid, rx_cd, p_error, addr_rd,
        input  tx_data, tx_cd, tx_ready, rd_data, busy, done
    );

    modport slave (
        input  start, rx_data, rx_valid, rx_cd, p_error, addr_rd,
        output tx_data, tx_cd, tx_ready, rd_data, busy, done
    );
endinterface

// File: rtl/device_rx.sv
// Remote-terminal receive path: accepts a receive command, stores its data
// words in a 32-entry RAM, then answers with a status word after a pause.
module device_rx #(
    parameter logic [4:0] ADDRESS    = 5'd1,
    parameter logic [7:0] PAUSE_TIME = 8'hFF,
    parameter logic [7:0] TIMEOUT    = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    device_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        PAUSE,
        LOAD_OS,
        SEND_OS,
        END
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_ram [0:31];
    logic [15:0] r_txData;
    logic [15:0] r_rdData;
    logic [4:0]  r_wordCnt;
    logic [4:0]  r_numWords;
    logic [7:0]  r_timer;
    logic        r_bcast;
    logic        r_err;
    logic        w_accept;
    logic        w_wordWr;
    logic        w_unused;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.rx_data[10] &&
                      ((bus.rx_data[15:11] == ADDRESS) || (bus.rx_data[15:11] == 5'd31));
    assign w_wordWr = (r_state == WAIT_DATA) && bus.rx_valid && !bus.rx_cd;
    assign w_unused = ^bus.rx_data[9:5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // N=0 encodes 32 words: numWords-1 wraps to 31, matching the counter wrap.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_nextState = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.rx_valid) begin
                    if (bus.rx_cd) begin
                        w_nextState = IDLE;
                    end else if (r_wordCnt == r_numWords - 5'd1) begin
                        w_nextState = PAUSE;
                    end
                end else if (r_timer == TIMEOUT) begin
                    w_nextState = IDLE;
                end
            end
            PAUSE: begin
                if (r_timer == PAUSE_TIME) w_nextState = r_bcast ? END : LOAD_OS;
            end
            LOAD_OS: w_nextState = SEND_OS;
            SEND_OS: begin
                if (r_timer == 8'd1) w_nextState = END;
            end
            END:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.tx_ready = 1'b0;
        case (r_state)
            WAIT_DATA, PAUSE, LOAD_OS: bus.busy = 1'b1;
            SEND_OS: begin
                bus.busy     = 1'b1;
                bus.tx_ready = 1'b1;
            end
            END: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: bus.busy = 1'b0;
        endcase
    end

    // One timer serves WAIT_DATA idle time, the pause and the send hold;
    // it restarts on every state change and on every stored word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_numWords <= 5'd0;
            r_bcast    <= 1'b0;
            r_err      <= 1'b0;
            r_wordCnt  <= 5'd0;
            r_timer    <= 8'd0;
            r_txData   <= 16'd0;
        end else begin
            if (w_accept) begin
                r_numWords <= bus.rx_data[4:0];
                r_bcast    <= (bus.rx_data[15:11] == 5'd31);
                r_err      <= bus.p_error;
                r_wordCnt  <= 5'd0;
            end else if (w_wordWr) begin
                r_err     <= r_err | bus.p_error;
                r_wordCnt <= r_wordCnt + 5'd1;
            end
            if ((r_state != w_nextState) || w_wordWr) begin
                r_timer <= 8'd0;
            end else if (r_state != IDLE) begin
                r_timer <= r_timer + 8'd1;
            end
            if (r_state == LOAD_OS) begin
                r_txData <= {ADDRESS, r_err, 10'd0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wordWr) begin
            r_ram[r_wordCnt] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdData <= 16'd0;
        end else begin
            r_rdData <= r_ram[bus.addr_rd];
        end
    end

    assign bus.tx_data = r_txData;
    assign bus.tx_cd   = 1'b0;
    assign bus.rd_data = r_rdData;

endmodule

// File: tb/tb_device_rx.sv
// Bench for device_rx: directed message table, a corner-case sequence and
// randomized messages checked against a message-level reference model.
module tb_device_rx;

    localparam int PAUSE_I   = 255;
    localparam int TIMEOUT_I = 255;

    typedef struct {
        logic [15:0] cmd;
        int          nSend;
        int          errWord;
        int          gap;
        int          abortMode;
        logic        expBusy;
        int          expReady;
        int          expDone;
        logic [15:0] expStatus;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    device_rx_if bus();

    device_rx #(
        .ADDRESS    (5'd1),
        .PAUSE_TIME (8'hFF),
        .TIMEOUT    (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          numChecks = 0;
    int          numFails  = 0;
    int          cycleCnt  = 0;
    int          readyCnt;
    int          doneCnt;
    int          firstReady;
    int          lastReady;
    int          doneCycle;
    int          lastWordCycle;
    logic        busySeen;
    logic        cdSeen;
    logic [15:0] lastStatus;
    string       curTag;
    logic [15:0] words [32];
    logic [15:0] shadow [32];
    logic        shadowValid [32];
    vec_t        vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s (%s): got 0x%0h, expected 0x%0h", name, curTag, act, exp);
        end
    endtask

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic step();
        @(negedge clk);
        cycleCnt++;
        if (bus.tx_ready === 1'b1) begin
            readyCnt++;
            if (firstReady < 0) firstReady = cycleCnt;
            lastReady  = cycleCnt;
            lastStatus = bus.tx_data;
        end
        if (bus.done === 1'b1) begin
            doneCnt++;
            doneCycle = cycleCnt;
        end
        if (bus.busy === 1'b1) busySeen = 1'b1;
        if (bus.tx_cd !== 1'b0) cdSeen = 1'b1;
    endtask

    task automatic clearObs();
        readyCnt      = 0;
        doneCnt       = 0;
        firstReady    = -1;
        lastReady     = -1;
        doneCycle     = -1;
        lastWordCycle = cycleCnt;
        busySeen      = 1'b0;
        cdSeen        = 1'b0;
        lastStatus    = 16'd0;
    endtask

    task automatic idleInputs();
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_cd    = 1'b0;
        bus.p_error  = 1'b0;
    endtask

    // Message-level reference: what a correct terminal does with this message.
    task automatic modelMessage(input logic [15:0] cmd, input int nSend, input int errWord,
                                input int gap, input int abortMode, output vec_t v);
        int   n;
        logic acc;
        logic bc;
        logic completes;
        logic errAny;
        acc       = !cmd[10] && ((cmd[15:11] == 5'd1) || (cmd[15:11] == 5'd31));
        bc        = (cmd[15:11] == 5'd31);
        n         = (cmd[4:0] == 5'd0) ? 32 : int'(cmd[4:0]);
        completes = acc && (gap <= TIMEOUT_I) && (nSend == n) && (abortMode != 3);
        errAny    = (errWord >= 0) && (errWord < nSend);
        v.cmd       = cmd;
        v.nSend     = nSend;
        v.errWord   = errWord;
        v.gap       = gap;
        v.abortMode = abortMode;
        v.expBusy   = acc;
        v.expReady  = (completes && !bc) ? 2 : 0;
        v.expDone   = completes ? 1 : 0;
        v.expStatus = {5'd1, errAny, 10'd0};
    endtask

    task automatic updateShadow(input vec_t v);
        logic acc;
        acc = !v.cmd[10] && ((v.cmd[15:11] == 5'd1) || (v.cmd[15:11] == 5'd31));
        if (acc && (v.gap <= TIMEOUT_I)) begin
            for (int i = 0; i < v.nSend; i++) begin
                shadow[i]      = words[i];
                shadowValid[i] = 1'b1;
            end
        end
    endtask

    task automatic readRam();
        for (int a = 0; a < 32; a++) begin
            if (shadowValid[a]) begin
                bus.addr_rd = 5'(a);
                step();
                checkOutput($sformatf("rd_data[%0d]", a), bus.rd_data, shadow[a]);
            end
        end
    endtask

    task automatic runMessage(input vec_t v);
        clearObs();
        step();
        bus.start   = 1'b1;
        bus.rx_data = v.cmd;
        for (int i = 0; i < v.nSend; i++) begin
            step();
            idleInputs();
            repeat (v.gap) step();
            bus.rx_valid  = 1'b1;
            bus.rx_cd     = 1'b0;
            bus.rx_data   = words[i];
            bus.p_error   = (i == v.errWord);
            lastWordCycle = cycleCnt;
        end
        step();
        idleInputs();
        if (v.abortMode == 2) begin
            bus.rx_valid = 1'b1;
            bus.rx_cd    = 1'b1;
            bus.rx_data  = 16'hDEAD;
            step();
            idleInputs();
        end else if (v.abortMode == 3) begin
            reset = 1'b1;
            #1;
            checkOutput("busy in reset", bus.busy, 1'b0);
            checkOutput("tx_data in reset", bus.tx_data, 16'd0);
            checkOutput("rd_data in reset", bus.rd_data, 16'd0);
            step();
            reset = 1'b0;
        end
        repeat (300) step();
    endtask

    task automatic applyStimulus(input vec_t v);
        runMessage(v);
        checkOutput("busy seen", busySeen, v.expBusy);
        checkOutput("tx_ready cycles", readyCnt, v.expReady);
        checkOutput("done pulses", doneCnt, v.expDone);
        checkOutput("tx_cd low", cdSeen, 1'b0);
        checkOutput("busy at end", bus.busy, 1'b0);
        if (v.expReady > 0) begin
            checkOutput("status word", lastStatus, v.expStatus);
            checkOutput("tx_ready contiguous", lastReady - firstReady, 1);
            checkOutput("status latency", firstReady - lastWordCycle, PAUSE_I + 3);
        end
        if (v.expDone > 0) begin
            checkOutput("done latency", doneCycle - lastWordCycle,
                        (v.cmd[15:11] == 5'd31) ? PAUSE_I + 2 : PAUSE_I + 5);
        end
        updateShadow(v);
        readRam();
    endtask

    initial begin
        vec_t        rv;
        logic [15:0] old0;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [4:0]  addr;
        int          n;
        int          nSend;
        int          errWord;
        int          abortMode;

        // cmd, nSend, errWord, gap, abort(0 none,1 silence,2 cd word,3 reset), busy, ready, done, status
        vecs[0]  = '{16'h0843,  3, -1,   0, 0, 1'b1, 2, 1, 16'h0800};
        vecs[1]  = '{16'h0840, 32, -1,   0, 0, 1'b1, 2, 1, 16'h0800};
        vecs[2]  = '{16'h0843,  3,  1,   0, 0, 1'b1, 2, 1, 16'h0C00};
        vecs[3]  = '{16'h1043,  3, -1,   0, 0, 1'b0, 0, 0, 16'h0000};
        vecs[4]  = '{16'h0C43,  3, -1,   0, 0, 1'b0, 0, 0, 16'h0000};
        vecs[5]  = '{16'hF843,  3, -1,   0, 0, 1'b1, 0, 1, 16'h0000};
        vecs[6]  = '{16'h0843,  1, -1,   0, 1, 1'b1, 0, 0, 16'h0000};
        vecs[7]  = '{16'h0843,  1, -1,   0, 2, 1'b1, 0, 0, 16'h0000};
        vecs[8]  = '{16'h0843,  1, -1,   0, 3, 1'b1, 0, 0, 16'h0000};
        vecs[9]  = '{16'h0843,  3, -1,   0, 0, 1'b1, 2, 1, 16'h0800};
        vecs[10] = '{16'h0842,  2, -1, 255, 0, 1'b1, 2, 1, 16'h0800};
        vecs[11] = '{16'h0842,  2, -1, 256, 0, 1'b1, 0, 0, 16'h0000};

        for (int a = 0; a < 32; a++) shadowValid[a] = 1'b0;
        idleInputs();
        bus.rx_data = 16'd0;
        bus.addr_rd = 5'd0;
        reset       = 1'b1;
        clearObs();
        curTag = "reset";
        repeat (3) step();
        checkOutput("tx_data", bus.tx_data, 16'd0);
        checkOutput("tx_cd", bus.tx_cd, 1'b0);
        checkOutput("tx_ready", bus.tx_ready, 1'b0);
        checkOutput("busy", bus.busy, 1'b0);
        checkOutput("done", bus.done, 1'b0);
        checkOutput("rd_data", bus.rd_data, 16'd0);
        reset = 1'b0;
        step();

        for (int k = 0; k < 12; k++) begin
            curTag = $sformatf("vec %0d cmd 0x%04h", k, vecs[k].cmd);
            for (int j = 0; j < 32; j++) words[j] = (k == 0) ? 16'hA001 + 16'(j) : 16'($urandom);
            applyStimulus(vecs[k]);
        end

        // Same-cycle read of the address being written, rx_valid in IDLE, start while busy.
        curTag = "corner";
        w0     = 16'($urandom);
        w1     = 16'($urandom);
        old0   = shadow[0];
        clearObs();
        step();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h5A5A;
        step();
        idleInputs();
        bus.start   = 1'b1;
        bus.rx_data = 16'h0842;
        step();
        idleInputs();
        bus.rx_valid = 1'b1;
        bus.rx_data  = w0;
        bus.addr_rd  = 5'd0;
        step();
        idleInputs();
        checkOutput("read during write", bus.rd_data, old0);
        bus.start   = 1'b1;
        bus.rx_data = 16'h0841;
        step();
        idleInputs();
        checkOutput("read after write", bus.rd_data, w0);
        bus.rx_valid  = 1'b1;
        bus.rx_data   = w1;
        lastWordCycle = cycleCnt;
        step();
        idleInputs();
        repeat (300) step();
        checkOutput("corner tx_ready cycles", readyCnt, 2);
        checkOutput("corner done pulses", doneCnt, 1);
        checkOutput("corner status", lastStatus, 16'h0800);
        checkOutput("corner latency", firstReady - lastWordCycle, PAUSE_I + 3);
        shadow[0] = w0;
        shadow[1] = w1;
        shadowValid[0] = 1'b1;
        shadowValid[1] = 1'b1;
        readRam();

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       addr = 5'd1;
                1:       addr = 5'd31;
                2:       addr = 5'($urandom);
                default: addr = 5'd1;
            endcase
            n         = int'($urandom_range(1, 6));
            abortMode = ($urandom_range(0, 4) == 0) ? 2 : 0;
            nSend     = (abortMode == 2) ? int'($urandom_range(0, n - 1)) : n;
            errWord   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            for (int j = 0; j < 32; j++) words[j] = 16'($urandom);
            modelMessage({addr, ($urandom_range(0, 5) == 0), 5'd0, 5'(n)}, nSend, errWord,
                         int'($urandom_range(0, 4)), abortMode, rv);
            curTag = $sformatf("random %0d cmd 0x%04h", k, rv.cmd);
            applyStimulus(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
